// File: rtl/regbank_pkg.sv
// Shared constants and request payload type for the register-bank write arbiter.
package regbank_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [ADDR_W-1:0] R0 = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // A destination is writable unless it is R0 or lies beyond the implemented registers.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr != R0) && (addr < ADDR_W'(NUM_REGS));
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last_grant pointer moves only when a grant is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank write port between the ALU and load write-back paths.
// Optional read-port forwarding outputs are enabled by defining REGBANK_WR_FWD_EN.
module regbank_write_arbiter
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] regD,
    output logic [DATA_W-1:0] writeData,
`ifdef REGBANK_WR_FWD_EN
    input  logic [ADDR_W-1:0] rd_addr_s,
    input  logic [ADDR_W-1:0] rd_addr_t,
    output logic              fwd_s_hit,
    output logic              fwd_t_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              illegal_wr,
    input  logic              illegal_clr
);

    wr_req_t           w_req0;
    wr_req_t           w_req1;
    wr_req_t           w_sel;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic              w_legal;

    logic              r_reg_write;
    logic [ADDR_W-1:0] r_reg_d;
    logic [DATA_W-1:0] r_write_data;
    logic              r_illegal_wr;

    assign w_req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign w_req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

    // Reset and stall hide both requests from the arbiter so nothing is accepted.
    assign w_req = {req1_valid, req0_valid} & {2{~(rst | stall)}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_xfer),
        .gnt     (w_gnt)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    always_comb begin
        w_sel = '0;
        if (w_gnt[1]) begin
            w_sel = w_req1;
        end else if (w_gnt[0]) begin
            w_sel = w_req0;
        end
    end

    assign w_xfer  = w_sel.valid;
    assign w_legal = addr_legal(w_sel.addr);

    // Write-port register: illegal destinations still load address/data but never enable the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_reg_d      <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_xfer & w_legal;
            if (w_xfer) begin
                r_reg_d      <= w_sel.addr;
                r_write_data <= w_sel.data;
            end
        end
    end

    // Sticky error flag; a new illegal acceptance takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_wr <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_illegal_wr <= 1'b1;
        end else if (illegal_clr) begin
            r_illegal_wr <= 1'b0;
        end
    end

    assign regWrite   = r_reg_write;
    assign regD       = r_reg_d;
    assign writeData  = r_write_data;
    assign illegal_wr = r_illegal_wr;

`ifdef REGBANK_WR_FWD_EN
    assign fwd_s_hit = r_reg_write && (r_reg_d == rd_addr_s);
    assign fwd_t_hit = r_reg_write && (r_reg_d == rd_addr_t);
    assign fwd_data  = r_write_data;
`endif

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the single write port of the 16-entry, 32-bit register bank between two write-back requesters.
  - Requester 0: ALU result path.
  - Requester 1: memory/load return path.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives registered regWrite/regD/writeData into the bank.
- Blocks writes to R0 and out-of-range registers; records such attempts in a sticky error flag.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (matches bank regD).
- NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  pipeline freeze; no grants while high.
- req0_valid  in  1  ALU write request.
- req0_ready  out  1  ALU request accepted this cycle.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU write data.
- req1_valid  in  1  memory write request.
- req1_ready  out  1  memory request accepted this cycle.
- req1_addr  in  ADDR_W  memory destination register.
- req1_data  in  DATA_W  memory write data.
- regWrite  out  1  bank write enable (registered).
- regD  out  ADDR_W  bank write address (registered).
- writeData  out  DATA_W  bank write data (registered).
- illegal_wr  out  1  sticky: a write to R0 or to an address >= NUM_REGS was accepted.
- illegal_clr  in  1  clears illegal_wr.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. Reset takes effect at the clk edge with rst=1.
  - Outputs after reset: regWrite=0, regD=0, writeData=0, illegal_wr=0.
  - Internal: last_grant=1, so requester 0 wins the first contention.
- Readies are combinational from valid, stall, rst and last_grant:
  - rst=1 or stall=1 -> both readies 0.
  - Only one valid -> that requester's ready=1.
  - Both valid -> ready goes to the requester != last_grant; the other sees ready=0 and must hold valid/addr/data stable.
- A transfer occurs on a clk edge with valid&ready. Only one transfer per cycle.
- last_grant updates only on a transfer. Idle and stall cycles do not move the pointer.
- Latency: a request accepted at edge N drives regWrite/regD/writeData during cycle N+1. The bank captures the write at edge N+1.
- Legality check on the accepted request:
  - addr==0 or addr>=NUM_REGS -> regWrite=0 next cycle, regD/writeData still loaded, illegal_wr set.
  - Otherwise regWrite=1.
- No transfer -> regWrite=0 next cycle; regD/writeData hold their previous values.
- illegal_wr set and illegal_clr in the same cycle -> set wins.
- Reset mid-operation: a request presented in the rst cycle is not accepted. A write already registered is squashed (regWrite=0 after the edge).
- Stall asserted with regWrite=1 already registered: that write still completes. Stall only blocks new acceptances.
- Strict alternation under continuous contention; neither requester waits more than 1 cycle beyond the other's grant.

Optional Feature:
- Macro: REGBANK_WR_FWD_EN.
- Defined -> adds:
  - inputs rd_addr_s, rd_addr_t (ADDR_W each).
  - outputs fwd_s_hit, fwd_t_hit (1 each) and fwd_data (DATA_W).
  - Behaviour: fwd_x_hit = regWrite & (regD==rd_addr_x), combinational; fwd_data=writeData. The decode stage uses these to bypass the bank's read-before-write ordering.
- Not defined -> ports absent, no logic.

Decomposition:
- Shared package regbank_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - R0 address constant.
  - typedef wr_req_t {valid, addr, data}.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot gnt[1:0].
  - Holds the last_grant flop.

Test Plan:
- Reset, then req0 only: addr=3, data=0xDEADBEEF -> req0_ready=1 that cycle; next cycle regWrite=1, regD=3, writeData=0xDEADBEEF.
- Both valid for 4 cycles: req0 addr=1/data=0x11, req1 addr=2/data=0x22 -> grant order req0, req1, req0, req1; regD sequence 1,2,1,2 one cycle later.
- req1 write to addr=0, then req0 write to addr=20 -> regWrite=0 both times, illegal_wr=1; illegal_clr pulse -> illegal_wr=0.
- stall=1 for 3 cycles with both valid -> readies 0, regWrite=0 after the pending write drains; after release, grant goes to req != last_grant.
- rst pulse while req0 valid (addr=5) and a write is registered -> no acceptance, regWrite=0 after the edge, next contention grants req0.
- REGBANK_WR_FWD_EN: write addr=7/data=0x1234 registered, rd_addr_s=7, rd_addr_t=8 -> fwd_s_hit=1, fwd_t_hit=0, fwd_data=0x1234.
